fifo_uart_tx: RTL and testbench

- Read-side consumer of the 8-bit async FIFO; lives entirely in the read clock domain.
- Pops bytes through the FIFO's show-ahead read interface and serialises each one as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, one stop bit.
- Supports back-to-back frames with zero idle gap and flow control via tx_en.

---
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Read-side consumer of the 8-bit async FIFO. It pops bytes through the FIFO's
// show-ahead interface and sends each one as a UART frame: start bit, 8 data
// bits LSB first, an optional parity bit, and one stop bit. Frames can run
// back to back with no idle gap. tx_en gates the start of new frames.
//
// State table:
//   IDLE  | line idle high, waiting for tx_en and a non-empty FIFO
//   START | start bit (line low)
//   DATA  | 8 data bits, LSB first, from the shift register
//   PAR   | parity bit (only when PARITY != 0)
//   STOP  | stop bit (line high); the last cycle may pop the next byte
//
// Ports:
//   rd_clk, rd_rstn  FIFO read clock; asynchronous active-low reset
//   fifo_rd_data     show-ahead FIFO data, valid while fifo_rd_empty = 0
//   fifo_rd_empty    FIFO empty flag
//   fifo_rd_en       single-cycle pop strobe (combinational)
//   tx_en            permission to start new frames
//   tx               registered serial line, idle high
//   busy             high while a frame is in progress
//   tx_done          one-cycle pulse in the last stop-bit cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic       rd_clk,
    input  logic       rd_rstn,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_rd_empty,
    output logic       fifo_rd_en,
    input  logic       tx_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shift, shift_n;
    logic            par_bit, par_n;
    logic            tx_n;
    logic            bit_last;
    logic            pop_ok;

    assign bit_last = (baud_cnt == BAUD_LAST);

    // A pop is possible only from IDLE or the final STOP cycle. That keeps the
    // FSM at least two bit times clear of a pop after the previous one, so the
    // FIFO's registered empty flag has time to settle.
    assign pop_ok     = tx_en & ~fifo_rd_empty &
                        ((state == IDLE) | ((state == STOP) & bit_last));
    assign fifo_rd_en = rd_rstn & pop_ok;
    assign busy       = (state != IDLE);
    assign tx_done    = (state == STOP) & bit_last;

    always_comb begin
        state_n = state;
        baud_n  = bit_last ? '0 : baud_cnt + CW'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_bit;

        case (state)
            IDLE: begin
                baud_n = '0;
                if (pop_ok) begin
                    state_n = START;
                    shift_n = fifo_rd_data;
                    par_n   = (PARITY == 2) ? ~^fifo_rd_data : ^fifo_rd_data;
                end
            end
            START: begin
                if (bit_last) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (PARITY != 0) state_n = PAR;
                        else             state_n = STOP;
                    end
                end
            end
            PAR: begin
                if (bit_last) state_n = STOP;
            end
            STOP: begin
                if (bit_last) begin
                    if (pop_ok) begin
                        state_n = START;
                        shift_n = fifo_rd_data;
                        par_n   = (PARITY == 2) ? ~^fifo_rd_data : ^fifo_rd_data;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state's line value so that the line
        // stays aligned with the state register (pop in cycle N, start bit
        // from edge N+1).
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PAR:     tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx. A behavioural FIFO, a cycle-level frame checker,
// and a UART receiver model check the main instance (CLKS_PER_BIT=4, no parity).
// Two further instances check even and odd parity.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       rd_clk  = 1'b0;
    logic       rd_rstn = 1'b1;
    logic       tx_en   = 1'b0;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en, tx, busy, tx_done;

    logic       par_go    = 1'b0;
    logic       par_empty = 1'b1;
    logic [7:0] par_data  = 8'h07;
    logic       rd_en_e, rd_en_o, tx_e, tx_o, busy_e, busy_o, done_e, done_o;

    always #5 rd_clk = ~rd_clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .fifo_rd_data(fifo_data),
        .fifo_rd_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .tx_en(tx_en),
        .tx(tx), .busy(busy), .tx_done(tx_done));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut_even (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .fifo_rd_data(par_data),
        .fifo_rd_empty(par_empty), .fifo_rd_en(rd_en_e), .tx_en(tx_en),
        .tx(tx_e), .busy(busy_e), .tx_done(done_e));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut_odd (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .fifo_rd_data(par_data),
        .fifo_rd_empty(par_empty), .fifo_rd_en(rd_en_o), .tx_en(tx_en),
        .tx(tx_o), .busy(busy_o), .tx_done(done_o));

    int n_vec  = 0;
    int n_err  = 0;
    int n_pops = 0;

    logic [7:0] q[$];
    logic [7:0] wq[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    logic       chk_on = 1'b0;
    logic       rx_on  = 1'b0;
    int         rx_ph  = -1;
    logic [7:0] rx_sh  = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge rd_clk);
        #1;
    endtask

    // Behavioural FIFO: writes land at the next rising edge, empty flag registered.
    initial forever begin
        @(posedge rd_clk);
        if (fifo_rd_en) begin
            chk("pop_nonempty", q.size() != 0, 1);
            if (q.size() != 0) q.delete(0);
            n_pops++;
        end
        while (wq.size() != 0) begin
            q.push_back(wq[0]);
            wq.delete(0);
        end
        fifo_empty <= (q.size() == 0);
        fifo_data  <= (q.size() != 0) ? q[0] : 8'h00;
    end

    // One-entry source for the parity instances.
    initial forever begin
        @(posedge rd_clk);
        if (par_go)                  par_empty <= 1'b0;
        else if (rd_en_e | rd_en_o)  par_empty <= 1'b1;
    end

    // Pop-rule monitor and UART receiver model (mid-bit sampling).
    initial forever begin
        @(negedge rd_clk);
        #1;
        if (chk_on) begin
            if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 0);
            if (!busy && !fifo_empty && tx_en) chk("pop_first_nonempty", fifo_rd_en, 1);
        end
        if (rx_on) begin
            if (rx_ph < 0) begin
                if (!tx) rx_ph = 0;
            end else begin
                rx_ph++;
            end
            if (rx_ph >= 0 && (rx_ph % CPB) == CPB / 2) begin
                if (rx_ph / CPB == 0) begin
                    chk("rx_start", tx, 0);
                end else if (rx_ph / CPB <= 8) begin
                    rx_sh[rx_ph / CPB - 1] = tx;
                end else begin
                    chk("rx_stop", tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_ph = -1;
                end
            end
        end
    end

    task automatic wait_pop(input string name);
        logic got;
        got = 1'b0;
        #1;
        for (int t = 0; t < 20; t++) begin
            if (fifo_rd_en) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_pop"}, got, 1);
    endtask

    // Checks nfr consecutive frames cycle by cycle from the pop onwards.
    task automatic check_stream(input string name, input int nfr,
                                input logic [9:0] f0, input logic [9:0] f1,
                                input int drop_at);
        logic [9:0] fr;
        int fi, bi;
        wait_pop(name);
        for (int k = 1; k <= 10 * CPB * nfr; k++) begin
            tick();
            fi = (k - 1) / (10 * CPB);
            bi = ((k - 1) % (10 * CPB)) / CPB;
            fr = (fi == 0) ? f0 : f1;
            chk({name, "_tx"}, tx, fr[bi]);
            chk({name, "_busy"}, busy, 1);
            chk({name, "_done"}, tx_done, (k % (10 * CPB)) == 0);
            chk({name, "_rd_en"}, fifo_rd_en,
                ((k % (10 * CPB)) == 0) && (k < 10 * CPB * nfr));
            if (k == drop_at) tx_en = 1'b0;
        end
        tick();
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_tx_end"}, tx, 1);
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({name, "_tx"}, tx, 1);
            chk({name, "_busy"}, busy, 0);
            chk({name, "_rd_en"}, fifo_rd_en, 0);
        end
    endtask

    initial begin
        logic [10:0] pe, po;
        logic [7:0]  b;
        logic        got;
        int          p0;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        #1 rd_rstn = 1'b0;
        tx_en = 1'b1;
        repeat (3) tick();
        wq.push_back(vecs[0].data);
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        rd_rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (i > 0) wq.push_back(vecs[i].data);
            check_stream($sformatf("vec%0d", i), 1, vecs[i].frame, 10'h000, 0);
        end

        wq.push_back(8'h00);
        wq.push_back(8'hFF);
        check_stream("b2b", 2, 10'b1000000000, 10'b1111111110, 0);

        // 0x07 with parity: start, 1,1,1,0,0,0,0,0, parity, stop
        pe = 11'b11000001110;
        po = 11'b10000001110;
        par_go = 1'b1;
        tick();
        par_go = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (rd_en_e) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("par_pop_even", got, 1);
        chk("par_pop_odd", rd_en_o, 1);
        for (int k = 1; k <= 11 * CPB; k++) begin
            tick();
            chk("par_even_tx", tx_e, pe[(k - 1) / CPB]);
            chk("par_odd_tx", tx_o, po[(k - 1) / CPB]);
            chk("par_even_done", done_e, k == 11 * CPB);
            chk("par_odd_done", done_o, k == 11 * CPB);
        end
        tick();
        chk("par_even_busy_end", busy_e, 0);
        chk("par_odd_busy_end", busy_o, 0);

        tx_en = 1'b0;
        wq.push_back(8'h3C);
        wq.push_back(8'h81);
        idle_check("fc_hold", 50);
        tx_en = 1'b1;
        check_stream("fc1", 1, vecs[3].frame, 10'h000, 20);
        idle_check("fc_stall", 30);
        tx_en = 1'b1;
        check_stream("fc2", 1, vecs[4].frame, 10'h000, 0);

        chk_on = 1'b1;
        rx_on  = 1'b1;
        rx_q.delete();
        exp_q.delete();
        p0 = n_pops;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 60)) tick();
            b = 8'($urandom);
            wq.push_back(b);
            exp_q.push_back(b);
        end
        got = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            tick();
            if (q.size() == 0 && wq.size() == 0 && !busy && rx_ph < 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("rnd_drain", got, 1);
        chk_on = 1'b0;
        rx_on  = 1'b0;
        chk("rnd_pops", n_pops - p0, 16);
        chk("rnd_rx_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) chk($sformatf("rnd_byte%0d", i), rx_q[i], exp_q[i]);
        end

        wq.push_back(8'hA5);
        wait_pop("rst_mid");
        repeat (15) tick();
        chk("rst_mid_busy_pre", busy, 1);
        rd_rstn = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rd_en", fifo_rd_en, 0);
        wq.push_back(8'h3C);
        repeat (3) tick();
        chk("rst_mid_rd_en_held", fifo_rd_en, 0);
        chk("rst_mid_tx_held", tx, 1);
        rd_rstn = 1'b1;
        check_stream("after_rst", 1, vecs[3].frame, 10'h000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
